// File: rtl/ifft_overlap_add_if.sv
// ---------------------------------------------------------------------------
// ifft_overlap_add_if
// Bundles the IFFT word stream and the audio playback signals of
// ifft_overlap_add.
//   ifft_valid / ifft_real / ifft_ready : IFFT frame words, transfer = valid & ready
//   frame_done                          : pulse when word N-1 of a frame is absorbed
//   sample_tick                         : audio sample strobe
//   audio_out / audio_valid             : played sample and its update pulse
//   underrun                            : sticky playback-starvation flag
// master = upstream/driver side, slave = the overlap-add block.
// ---------------------------------------------------------------------------
interface ifft_overlap_add_if #(
   parameter int Nb    = 18,
   parameter int OUT_W = 16
);
   logic                    ifft_valid;
   logic signed [Nb-1:0]    ifft_real;
   logic                    ifft_ready;
   logic                    frame_done;
   logic                    sample_tick;
   logic signed [OUT_W-1:0] audio_out;
   logic                    audio_valid;
   logic                    underrun;

   modport master (
      output ifft_valid, ifft_real, sample_tick,
      input  ifft_ready, frame_done, audio_out, audio_valid, underrun
   );

   modport slave (
      input  ifft_valid, ifft_real, sample_tick,
      output ifft_ready, frame_done, audio_out, audio_valid, underrun
   );
endinterface

// File: rtl/ifft_overlap_add.sv
// ---------------------------------------------------------------------------
// ifft_overlap_add
// Absorbs N-point IFFT frames (real part, index order), overlap-adds the first
// half of each frame with the saved second half of the previous frame, scales
// by >>> OUT_SHIFT, saturates to OUT_W and stores the HOP results into one
// bank of a ping-pong buffer. Playback reads one sample per sample_tick from
// the other bank, two cycles after the tick.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : ifft_overlap_add_if.slave (IFFT stream in, audio samples out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module ifft_overlap_add #(
   parameter int Nb        = 18,
   parameter int log_depth = 9,
   parameter int OUT_W     = 16,
   parameter int OUT_SHIFT = 2
) (
   input  logic              clk,
   input  logic              reset,
   ifft_overlap_add_if.slave bus
);
   localparam int N   = 32'sd1 <<< log_depth;
   localparam int HOP = N / 32'sd2;
   localparam int RW  = log_depth - 32'sd1;   // bank/tail address width

   localparam logic [log_depth-1:0] IDX_HEAD_LAST  = log_depth'(HOP - 32'sd1);
   localparam logic [log_depth-1:0] IDX_FRAME_LAST = log_depth'(N - 32'sd1);
   localparam logic [log_depth-1:0] IDX_ONE        = log_depth'(32'd1);
   localparam logic [RW-1:0]        RD_LAST        = RW'(HOP - 32'sd1);
   localparam logic [RW-1:0]        RD_ONE         = RW'(32'd1);
   localparam int SAT_MAX = (32'sd1 <<< (OUT_W - 32'sd1)) - 32'sd1;
   localparam int SAT_MIN = -(32'sd1 <<< (OUT_W - 32'sd1));

   typedef enum logic [0:0] {
      ACCEPT_HEAD = 1'b0,
      ACCEPT_TAIL = 1'b1
   } in_state_t;

   // Scale the overlap sum and clamp it into the signed OUT_W range.
   function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [Nb:0] sum);
      logic signed [Nb:0] shifted;
      int                 wide;
      shifted = sum >>> OUT_SHIFT;
      wide    = int'(shifted);
      if (wide > SAT_MAX) begin
         return OUT_W'(SAT_MAX);
      end else if (wide < SAT_MIN) begin
         return OUT_W'(SAT_MIN);
      end else begin
         return shifted[OUT_W-1:0];
      end
   endfunction

   // ---------------- state ----------------
   in_state_t               state_q, state_d;
   logic [log_depth-1:0]    idx_q, idx_d;
   logic                    wb_q, wb_d;
   logic                    rb_q, rb_d;
   logic [1:0]              full_q, full_d;
   logic                    tail_valid_q, tail_valid_d;
   logic                    started_q, started_d;
   logic [RW-1:0]           rd_idx_q, rd_idx_d;
   logic                    ifft_ready_q, ifft_ready_d;
   logic                    frame_done_q, frame_done_d;
   // playback pipeline stage 1
   logic                    tick_p1_q, tick_p1_d;
   logic                    hit_p1_q, hit_p1_d;
   logic                    urun_p1_q, urun_p1_d;
   logic signed [OUT_W-1:0] rd_data_q, rd_data_d;
   // playback stage 2 (outputs)
   logic signed [OUT_W-1:0] audio_out_q, audio_out_d;
   logic                    audio_valid_q, audio_valid_d;
   logic                    underrun_q, underrun_d;

   // storage (no reset: contents are qualified by full/tail_valid)
   logic signed [OUT_W-1:0] bank_mem [2][HOP];
   logic signed [Nb-1:0]    tail_mem [HOP];

   logic                    bank_we_s;
   logic signed [OUT_W-1:0] bank_wdata_s;
   logic                    tail_we_s;
   logic                    frame_end_s;
   logic                    release_s;
   logic                    xfer_s;
   logic signed [Nb-1:0]    tail_rd_s;
   logic signed [Nb:0]      head_sum_s;
   logic [1:0]              set_vec_s;
   logic [1:0]              rel_vec_s;

   assign xfer_s    = bus.ifft_valid & ifft_ready_q;
   // head words use idx directly, tail words use idx-HOP: both are the low bits
   assign tail_rd_s = tail_mem[idx_q[RW-1:0]];

   // Input FSM: route each accepted word to the bank (head) or tail store.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      wb_d         = wb_q;
      tail_valid_d = tail_valid_q;
      frame_done_d = 1'b0;
      frame_end_s  = 1'b0;
      bank_we_s    = 1'b0;
      tail_we_s    = 1'b0;
      head_sum_s   = {bus.ifft_real[Nb-1], bus.ifft_real};
      if (tail_valid_q) begin
         head_sum_s = head_sum_s + {tail_rd_s[Nb-1], tail_rd_s};
      end else begin
         head_sum_s = {bus.ifft_real[Nb-1], bus.ifft_real};
      end
      bank_wdata_s = sat_out(head_sum_s);
      if (xfer_s) begin
         case (state_q)
            ACCEPT_HEAD: begin
               bank_we_s = 1'b1;
               idx_d     = idx_q + IDX_ONE;
               if (idx_q == IDX_HEAD_LAST) begin
                  state_d = ACCEPT_TAIL;
               end else begin
                  state_d = ACCEPT_HEAD;
               end
            end
            ACCEPT_TAIL: begin
               tail_we_s = 1'b1;
               if (idx_q == IDX_FRAME_LAST) begin
                  frame_end_s  = 1'b1;
                  frame_done_d = 1'b1;
                  wb_d         = ~wb_q;
                  tail_valid_d = 1'b1;
                  idx_d        = '0;
                  state_d      = ACCEPT_HEAD;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = ACCEPT_TAIL;
               end
            end
            default: begin
               state_d = ACCEPT_HEAD;
               idx_d   = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Playback stage 1: consume a tick, read the bank, advance the read side.
   always_comb begin
      tick_p1_d = bus.sample_tick;
      hit_p1_d  = 1'b0;
      urun_p1_d = 1'b0;
      rd_data_d = rd_data_q;
      rd_idx_d  = rd_idx_q;
      rb_d      = rb_q;
      started_d = started_q;
      release_s = 1'b0;
      if (bus.sample_tick) begin
         if (full_q[rb_q]) begin
            hit_p1_d  = 1'b1;
            rd_data_d = bank_mem[rb_q][rd_idx_q];
            started_d = 1'b1;
            if (rd_idx_q == RD_LAST) begin
               release_s = 1'b1;
               rb_d      = ~rb_q;
               rd_idx_d  = '0;
            end else begin
               rd_idx_d  = rd_idx_q + RD_ONE;
            end
         end else begin
            // starved: only an error once playback has begun
            urun_p1_d = started_q;
         end
      end else begin
         hit_p1_d = 1'b0;
      end
   end

   // Playback stage 2: present the sample (or silence) and latch underrun.
   always_comb begin
      audio_valid_d = tick_p1_q;
      audio_out_d   = audio_out_q;
      underrun_d    = underrun_q | urun_p1_q;
      if (tick_p1_q) begin
         if (hit_p1_q) begin
            audio_out_d = rd_data_q;
         end else begin
            audio_out_d = '0;
         end
      end else begin
         audio_out_d = audio_out_q;
      end
   end

   // Bank occupancy: fill and release never target the same bank in one cycle.
   always_comb begin
      set_vec_s    = {frame_end_s & wb_q, frame_end_s & ~wb_q};
      rel_vec_s    = {release_s & rb_q, release_s & ~rb_q};
      full_d       = (full_q & ~rel_vec_s) | set_vec_s;
      ifft_ready_d = ~full_d[wb_d];
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ACCEPT_HEAD;
         idx_q         <= '0;
         wb_q          <= 1'b0;
         rb_q          <= 1'b0;
         full_q        <= 2'b00;
         tail_valid_q  <= 1'b0;
         started_q     <= 1'b0;
         rd_idx_q      <= '0;
         ifft_ready_q  <= 1'b1;
         frame_done_q  <= 1'b0;
         tick_p1_q     <= 1'b0;
         hit_p1_q      <= 1'b0;
         urun_p1_q     <= 1'b0;
         rd_data_q     <= '0;
         audio_out_q   <= '0;
         audio_valid_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         wb_q          <= wb_d;
         rb_q          <= rb_d;
         full_q        <= full_d;
         tail_valid_q  <= tail_valid_d;
         started_q     <= started_d;
         rd_idx_q      <= rd_idx_d;
         ifft_ready_q  <= ifft_ready_d;
         frame_done_q  <= frame_done_d;
         tick_p1_q     <= tick_p1_d;
         hit_p1_q      <= hit_p1_d;
         urun_p1_q     <= urun_p1_d;
         rd_data_q     <= rd_data_d;
         audio_out_q   <= audio_out_d;
         audio_valid_q <= audio_valid_d;
         underrun_q    <= underrun_d;
      end
   end

   // Sample and tail storage writes.
   always_ff @(posedge clk) begin
      if (bank_we_s) begin
         bank_mem[wb_q][idx_q[RW-1:0]] <= bank_wdata_s;
      end
      if (tail_we_s) begin
         tail_mem[idx_q[RW-1:0]] <= bus.ifft_real;
      end
   end

   assign bus.ifft_ready  = ifft_ready_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.audio_out   = audio_out_q;
   assign bus.audio_valid = audio_valid_q;
   assign bus.underrun    = underrun_q;

endmodule
